// File: rtl/dart_seq_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dart_seq_pkg : shared state, status codes and table-entry type   (rev 1.0)
// -----------------------------------------------------------------------------
package dart_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESENT = 3'd1,
    S_GAP     = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] ST_EMPTY     = 2'b00;
  localparam logic [1:0] ST_SET_LAST  = 2'b01;
  localparam logic [1:0] ST_SET_EARLY = 2'b10;
  localparam logic [1:0] ST_TIMEOUT   = 2'b11;

  // Entry layout for the default widths; the RAM word packs fields in this order.
  localparam int ENTRY_COORD_W = 8;
  localparam int ENTRY_HOLD_W  = 4;

  typedef struct packed {
    logic [ENTRY_COORD_W-1:0] x;
    logic [ENTRY_COORD_W-1:0] y;
    logic [ENTRY_HOLD_W-1:0]  hold;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/dart_entry_ram.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dart_entry_ram : throw table, synchronous write / asynchronous read (rev 1.0)
// -----------------------------------------------------------------------------
module dart_entry_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/dart_throw_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dart_throw_sequencer : replays a throw table into the scoring core and
// captures its game result                                          (rev 1.0)
// -----------------------------------------------------------------------------
module dart_throw_sequencer
  import dart_seq_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int DEPTH       = 16,
  parameter int NUM_PLAYERS = 2,
  parameter int PT_W        = 9,
  parameter int HOLD_W      = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(DEPTH)-1:0]      cfg_wr_addr,
  input  logic [COORD_W-1:0]            cfg_wr_x,
  input  logic [COORD_W-1:0]            cfg_wr_y,
  input  logic [HOLD_W-1:0]             cfg_wr_hold,
  input  logic [$clog2(DEPTH):0]        cfg_len,
  input  logic                          cfg_pulse,
  input  logic                          start,
  output logic                          busy_o,
  output logic                          dart_come_o,
  output logic [COORD_W-1:0]            dart_position_x_o,
  output logic [COORD_W-1:0]            dart_position_y_o,
  input  logic                          game_set_i,
  input  logic [NUM_PLAYERS-1:0]        player_win_i,
  input  logic [NUM_PLAYERS*PT_W-1:0]   player_pt_i,
  output logic                          seq_done_o,
  output logic [1:0]                    status_o,
  output logic [NUM_PLAYERS-1:0]        win_o,
  output logic [NUM_PLAYERS*PT_W-1:0]   pt_o,
  output logic [$clog2(DEPTH):0]        throws_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 * COORD_W + HOLD_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                      state_q, state_d;
  logic [AW-1:0]               idx_q, idx_d;
  logic [LW-1:0]               len_q, len_d;
  logic                        pulse_q, pulse_d;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic [TW-1:0]               wait_q, wait_d;
  logic [1:0]                  status_q, status_d;
  logic [NUM_PLAYERS-1:0]      win_q, win_d;
  logic [NUM_PLAYERS*PT_W-1:0] pt_q, pt_d;
  logic [LW-1:0]               throws_q, throws_d;

  logic [EW-1:0]               rd_data;
  logic [COORD_W-1:0]          ent_x, ent_y;
  logic [HOLD_W-1:0]           ent_hold;
  logic                        last_entry;

  dart_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (cfg_wr_en && (state_q == S_IDLE)),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i ({cfg_wr_x, cfg_wr_y, cfg_wr_hold}),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data)
  );

  assign {ent_x, ent_y, ent_hold} = rd_data;
  assign last_entry = ({1'b0, idx_q} == (len_q - LW'(1)));

  assign busy_o            = (state_q == S_PRESENT) || (state_q == S_GAP) || (state_q == S_WAIT);
  assign dart_come_o       = (state_q == S_PRESENT);
  assign dart_position_x_o = dart_come_o ? ent_x : '0;
  assign dart_position_y_o = dart_come_o ? ent_y : '0;
  assign seq_done_o        = (state_q == S_DONE);
  assign status_o          = status_q;
  assign win_o             = win_q;
  assign pt_o              = pt_q;
  assign throws_o          = throws_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    pulse_d  = pulse_q;
    hold_d   = hold_q;
    wait_d   = wait_q;
    status_d = status_q;
    win_d    = win_q;
    pt_d     = pt_q;
    throws_d = throws_q;

    // A game result wins over any same-cycle hold, gap or timeout transition.
    if (busy_o && game_set_i) begin
      state_d  = S_DONE;
      win_d    = player_win_i;
      pt_d     = player_pt_i;
      status_d = last_entry ? ST_SET_LAST : ST_SET_EARLY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_d    = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
            pulse_d  = cfg_pulse;
            idx_d    = '0;
            hold_d   = '0;
            wait_d   = '0;
            win_d    = '0;
            pt_d     = '0;
            status_d = ST_EMPTY;
            if (cfg_len == '0) begin
              throws_d = '0;
              state_d  = S_DONE;
            end else begin
              throws_d = LW'(1);
              state_d  = S_PRESENT;
            end
          end
        end
        S_PRESENT: begin
          if (hold_q == ent_hold) begin
            hold_d = '0;
            if (last_entry) begin
              wait_d  = '0;
              state_d = S_WAIT;
            end else begin
              idx_d = idx_q + 1'b1;
              if (pulse_q) begin
                state_d = S_GAP;
              end else begin
                throws_d = throws_q + 1'b1;
              end
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        S_GAP: begin
          throws_d = throws_q + 1'b1;
          state_d  = S_PRESENT;
        end
        S_WAIT: begin
          if (wait_q == TW'(TIMEOUT - 1)) begin
            status_d = ST_TIMEOUT;
            state_d  = S_DONE;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      pulse_q  <= 1'b0;
      hold_q   <= '0;
      wait_q   <= '0;
      status_q <= ST_EMPTY;
      win_q    <= '0;
      pt_q     <= '0;
      throws_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      pulse_q  <= pulse_d;
      hold_q   <= hold_d;
      wait_q   <= wait_d;
      status_q <= status_d;
      win_q    <= win_d;
      pt_q     <= pt_d;
      throws_q <= throws_d;
    end
  end

endmodule
`default_nettype wire
